// File: rtl/uart_tx_fifo_if.sv
// Byte-stream interface of the buffered UART transmitter.
//   wr_en/wr_data : producer write strobe and byte
//   full/empty    : FIFO occupancy flags (registered)
//   count         : bytes queued, not counting the byte on the line
//   tx            : serial line, idles high
//   active        : high for the whole frame, start bit through stop bit
//   done          : one-cycle pulse at the end of each stop bit
// The producer side uses the master modport; the transmitter uses slave.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              tx;
  logic              active;
  logic              done;

  modport master (
    output wr_en, wr_data,
    input  full, empty, count, tx, active, done
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, count, tx, active, done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a synchronous FIFO feeding a serializer.
// Producers push bytes in bursts; the FSM pops one byte whenever the line
// is idle and shifts it out LSB first with one start and one stop bit.
// Ports:
//   clk : system clock, everything on the rising edge
//   rst : synchronous active-high reset, flushes FIFO and aborts any frame
//   bus : uart_tx_fifo_if.slave (write port, FIFO flags, serial outputs)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_fifo_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   DEPTH     = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic              full_reg;
  logic              empty_reg;

  state_t            state_reg;
  logic [CNT_W-1:0]  clk_cnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [2:0]        bit_idx_next;
  logic [7:0]        shift_reg;
  logic              tx_reg;
  logic              active_reg;
  logic              done_reg;

  logic              wr_accept;
  logic              pop;

  // Full is taken from the registered flag, i.e. before any pop on this
  // edge, so a write into a full FIFO is dropped even if a pop frees a slot.
  assign wr_accept    = bus.wr_en & ~full_reg;
  assign pop          = (state_reg == IDLE) & ~empty_reg;
  assign bit_idx_next = bit_idx_reg + 3'd1;

  always_comb begin
    count_next = count_reg;
    if (wr_accept && !pop) begin
      count_next = count_reg + COUNT_ONE;
    end else if (!wr_accept && pop) begin
      count_next = count_reg - COUNT_ONE;
    end
  end

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH);
      empty_reg <= (count_next == '0);
    end
  end

  // Serializer. Outputs are registered and loaded with the value of the
  // state being entered, so tx changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      active_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          clk_cnt_reg <= '0;
          bit_idx_reg <= '0;
          if (pop) begin
            shift_reg  <= mem[rd_ptr_reg];
            state_reg  <= START;
            tx_reg     <= 1'b0;
            active_reg <= 1'b1;
          end else begin
            tx_reg     <= 1'b1;
            active_reg <= 1'b0;
          end
        end
        START: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_next;
              tx_reg      <= shift_reg[bit_idx_next];
            end
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
          end
        end
        STOP: begin
          if (clk_cnt_reg == CNT_LAST) begin
            clk_cnt_reg <= '0;
            state_reg   <= IDLE;
            done_reg    <= 1'b1;
            active_reg  <= 1'b0;
            tx_reg      <= 1'b1;
          end else begin
            clk_cnt_reg <= clk_cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg   <= IDLE;
          clk_cnt_reg <= '0;
          tx_reg      <= 1'b1;
          active_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.full   = full_reg;
  assign bus.empty  = empty_reg;
  assign bus.count  = count_reg;
  assign bus.tx     = tx_reg;
  assign bus.active = active_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A frame-level reference model (byte queue plus a frame timer, with the
// line level taken from the 10-bit frame word) runs alongside the DUT.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;

  uart_tx_fifo_if #(.ADDR_W(AW)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .ADDR_W      (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_on   = 1'b0;
  int         m_t    = 0;
  logic [9:0] m_word = 10'h3ff;
  bit         m_done = 1'b0;

  initial begin
    forever begin
      bit acc;
      @(posedge clk);
      acc    = bus.wr_en && (mq.size() < DEPTH);
      m_done = 1'b0;
      if (rst) begin
        mq.delete();
        m_on = 1'b0;
        m_t  = 0;
      end else begin
        if (m_on) begin
          m_t++;
          if (m_t == FRAME) begin
            m_on   = 1'b0;
            m_done = 1'b1;
            $display("frame sent byte=%h", m_word[8:1]);
          end
        end else if (mq.size() > 0) begin
          m_word = {1'b1, mq.pop_front(), 1'b0};
          m_on   = 1'b1;
          m_t    = 0;
        end
        if (acc) mq.push_back(bus.wr_data);
      end
    end
  end

  function automatic logic [2:0] exp_line();
    logic t;
    int   idx;
    t = 1'b1;
    if (m_on) begin
      idx = m_t / CPB;
      t   = m_word[idx];
    end
    return {t, m_on, m_done};
  endfunction

  function automatic logic [AW+2:0] exp_fifo();
    logic [AW:0] c;
    c = (AW + 1)'(mq.size());
    return {mq.size() == DEPTH, mq.size() == 0, c};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h55;
    repeat (2) @(negedge clk);
    bus.wr_en = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if ({bus.tx, bus.active, bus.done, bus.full, bus.empty, bus.count} !== {3'b100, 2'b01, 3'd0}) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", c,
                 {bus.tx, bus.active, bus.done, bus.full, bus.empty, bus.count}, 8'b10001000);
      end
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL reset_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
    end
  endtask

  task automatic test_single();
    bit   exp_bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic hist[46];
    int   fall = -1;
    int   act = 0;
    int   dn = 0;
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      bus.wr_en = 1'b0;
      hist[c] = bus.tx;
      if (bus.tx === 1'b0 && fall < 0) fall = c;
      if (bus.active === 1'b1) act++;
      if (bus.done === 1'b1) dn++;
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL single_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL single_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
    end
    total++;
    if (fall != 1) begin
      bad++;
      $display("FAIL single_latency got=%0d want=1", fall);
    end else begin
      for (int k = 0; k < 10; k++) begin
        for (int j = 0; j < CPB; j++) begin
          total++;
          if (hist[1 + k * CPB + j] !== exp_bits[k]) begin
            bad++;
            $display("FAIL single_bit bit=%0d sub=%0d got=%b want=%b", k, j, hist[1 + k * CPB + j], exp_bits[k]);
          end
        end
      end
    end
    total++;
    if (act != FRAME || dn != 1 || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL single_frame got active=%0d done=%0d empty=%b want active=%0d done=1 empty=1",
               act, dn, bus.empty, FRAME);
    end
  endtask

  task automatic test_burst();
    int dn = 0;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL burst_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL burst_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
      if (c == 5 || c == 6) begin
        total++;
        if (bus.full !== 1'b1 || bus.count !== 3'd4) begin
          bad++;
          $display("FAIL burst_full cyc=%0d got full=%b count=%0d want full=1 count=4", c, bus.full, bus.count);
        end
      end
      bus.wr_en = (c < 6);
      bus.wr_data = 8'(c + 1);
    end
    total++;
    if (dn != 5) begin
      bad++;
      $display("FAIL burst_done got=%0d want=5", dn);
    end
  endtask

  task automatic test_enqueue_in_flight();
    int dn = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL inflight_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL inflight_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
      if (c == 12 || c == 13) begin
        total++;
        if (bus.count !== ((c == 12) ? 3'd0 : 3'd1)) begin
          bad++;
          $display("FAIL inflight_count cyc=%0d got=%0d want=%0d", c, bus.count, (c == 12) ? 0 : 1);
        end
      end
      bus.wr_en = (c == 0) || (c == 12);
      bus.wr_data = (c == 0) ? 8'hFF : 8'h3C;
    end
    total++;
    if (dn != 2) begin
      bad++;
      $display("FAIL inflight_done got=%0d want=2", dn);
    end
  endtask

  task automatic test_full_pop();
    int trig = -1;
    for (int c = 0; c < 230; c++) begin
      @(negedge clk);
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL fullpop_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL fullpop_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
      if (trig >= 0 && c == trig + 1) begin
        total++;
        if (bus.count !== 3'd3 || bus.full !== 1'b0) begin
          bad++;
          $display("FAIL fullpop_drop got count=%0d full=%b want count=3 full=0", bus.count, bus.full);
        end
      end
      bus.wr_en = (c < 5);
      bus.wr_data = 8'($urandom);
      if (trig < 0 && m_done && mq.size() == DEPTH) begin
        trig = c;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEE;
      end
    end
    bus.wr_en = 1'b0;
    total++;
    if (trig < 0) begin
      bad++;
      $display("FAIL fullpop_trigger got=none want=pop cycle");
    end
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    int rc = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      rst = 1'b0;
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL rstmid_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL rstmid_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
      if (rc >= 0 && c > rc) begin
        total++;
        if ({bus.tx, bus.active, bus.empty, bus.count} !== {3'b101, 3'd0}) begin
          bad++;
          $display("FAIL rstmid_after cyc=%0d got=%b want=101000", c, {bus.tx, bus.active, bus.empty, bus.count});
        end
      end
      bus.wr_en = (c < 3);
      bus.wr_data = (c == 0) ? 8'h0F : 8'(8'hA0 + c);
      if (rc < 0 && m_on && m_t == 17) begin
        total++;
        if (bus.count !== 3'd2) begin
          bad++;
          $display("FAIL rstmid_queued got=%0d want=2", bus.count);
        end
        rst = 1'b1;
        rc = c;
      end
    end
    total++;
    if (dn != 0 || rc < 0) begin
      bad++;
      $display("FAIL rstmid_done got done=%0d reset_cyc=%0d want done=0 reset applied", dn, rc);
    end
  endtask

  task automatic test_random();
    int c = 0;
    while (c < 1400) begin
      @(negedge clk);
      total++;
      if ({bus.tx, bus.active, bus.done} !== exp_line()) begin
        bad++;
        $display("FAIL random_line cyc=%0d got=%b want=%b", c, {bus.tx, bus.active, bus.done}, exp_line());
      end
      total++;
      if ({bus.full, bus.empty, bus.count} !== exp_fifo()) begin
        bad++;
        $display("FAIL random_fifo cyc=%0d got=%b want=%b", c, {bus.full, bus.empty, bus.count}, exp_fifo());
      end
      bus.wr_en = (c < 800) && ($urandom_range(0, 24) == 0);
      bus.wr_data = 8'($urandom);
      if (c >= 800 && !m_on && mq.size() == 0) break;
      c++;
    end
    bus.wr_en = 1'b0;
    total++;
    if (c >= 1400) begin
      bad++;
      $display("FAIL random_drain got=timeout want=idle");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_enqueue_in_flight();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter: 8N1 serializer fed by an internal synchronous FIFO.
- Lets on-chip producers (status reporters, command responders) push bursts of bytes without waiting for the line to go idle.
- It is the transmit-side counterpart to the receive path that drives the board LEDs.
- Its serial output ties directly to the board's uart_tx pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); must be >= 2.
- FIFO_DEPTH, 16, FIFO entries; must be a power of 2, >= 2.
- ADDR_W, 4, log2(FIFO_DEPTH). Pointers are ADDR_W bits; count is ADDR_W+1 bits.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_wr_en  input  1  write strobe; pushes i_wr_data when o_full=0.
- i_wr_data  input  8  byte to transmit.
- o_full  output  1  FIFO holds FIFO_DEPTH bytes.
- o_empty  output  1  FIFO holds 0 bytes.
- o_count  output  ADDR_W+1  bytes currently queued, excluding the byte being serialized.
- o_tx  output  1  serial line; idles high.
- o_active  output  1  high while a frame is on the line (START through STOP).
- o_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (i_reset=1 sampled on an edge):
  - o_tx=1, o_active=0, o_done=0.
  - FIFO flushed: o_count=0, o_empty=1, o_full=0.
  - State goes to IDLE; bit counter and clock counter go to 0.
  - Reset mid-frame aborts the frame immediately; o_tx is high after that edge.
  - i_reset overrides a simultaneous i_wr_en.
- FIFO:
  - o_full, o_empty and o_count are registered and reflect state after the last edge.
  - A write is accepted iff i_wr_en=1 and o_full=0. Data goes to mem[wr_ptr], wr_ptr increments modulo FIFO_DEPTH, and count increments.
  - A write while full is dropped silently; no pointer or count change occurs.
  - full is evaluated before the same-cycle pop, so a write while full is dropped even if a pop happens on that edge.
  - A pop is issued only by the FSM, in IDLE with o_empty=0. The head byte loads into the shift register, rd_ptr increments modulo FIFO_DEPTH, and count decrements.
  - Simultaneous accepted write and pop: count unchanged, both pointers advance.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1, o_active=0. If o_empty=0, pop and go to START on the same edge.
  - START: o_tx=0, o_active=1, held for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=shift[bit_idx], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: o_tx=1, held CLKS_PER_BIT cycles. On the final cycle's edge, go to IDLE, assert o_done for exactly one cycle, and deassert o_active.
- Timing:
  - Latency: a write accepted at edge E while IDLE and empty makes o_empty=0 after E. The pop happens at E+1, and o_tx falls after E+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles of o_active=1.
  - Back-to-back frames have exactly one IDLE cycle (o_tx=1) between the stop bit and the next start bit.
- Writes during a frame only enqueue; they never disturb the byte in flight.
- The clock counter counts 0..CLKS_PER_BIT-1 and clears on every state or bit change.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, ADDR_W=2):
- Reset then idle 20 cycles -> o_tx=1, o_active=0, o_done=0, o_empty=1, o_count=0 throughout.
- Single write 8'hA5 at edge E -> o_tx falls after E+1. Line then carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles. o_active high 40 cycles, one o_done pulse, o_empty=1 after.
- Write 6 bytes 8'h01..8'h06 on consecutive cycles -> first byte pops immediately, 4 more are queued, and o_full=1 after the 5th write. 8'h06 is dropped. Line carries 8'h01..8'h05 with exactly one idle cycle between frames, then 5 o_done pulses.
- Write 8'h3C while frame 8'hFF is in flight, in the same cycle as no pop -> o_count 0->1. 8'hFF completes unchanged, then 8'h3C follows after one idle cycle.
- Fill FIFO, then write in the cycle the FSM pops -> write is dropped (full pre-pop) and o_count decrements by 1.
- Assert i_reset during DATA bit 3 of 8'h0F with 2 bytes queued -> after that edge o_tx=1, o_active=0, o_count=0, o_empty=1. No o_done, and no frame starts until a new write.
